rf_bypass_sb: RTL
=================

# rf_bypass_sb

Parametrised successor to the OTTER register file for the 5-stage pipeline. It provides:
- `NRD` combinational read ports with write-through bypass;
- a per-register busy scoreboard for hazard detection;
- a post-reset clear sequencer that zeroes the array one entry per cycle.

It sits in the decode stage: read and issue come from ID, and the write port is driven by WB.

## Interface
- `XLEN`, 32, data width
- `DEPTH`, 32, register count, power of two, ≥4
- `NRD`, 2, number of read ports
- `AW`, localparam `$clog2(DEPTH)`, address width
- `CLK`  in  1  clock
- `RST`  in  1  reset, asynchronous, active-high
- `RF_RADDR`  in  NRD*AW  packed read addresses; port i = `[i*AW +: AW]`
- `RF_RDATA`  out  NRD*XLEN  packed read data, same packing
- `RF_RBUSY`  out  NRD  per-port busy flag for the addressed register
- `RF_WA`  in  AW  write address
- `RF_WD`  in  XLEN  write data
- `RF_EN`  in  1  write enable; also clears the busy bit of `RF_WA`
- `RF_ISSUE_EN`  in  1  an instruction writing `RF_ISSUE_ADR` has issued
- `RF_ISSUE_ADR`  in  AW  destination of the issuing instruction
- `RF_READY`  out  1  array cleared, block accepting traffic

## Operation
FSM has two states, CLEAR and RUN.
- `RST` high forces CLEAR immediately (async), clear index = 0, all busy bits = 0.
- In CLEAR, each posedge writes 0 to `ram[index]` and increments index. At the edge where index == DEPTH-1, the FSM moves to RUN.
- The index counter is AW bits and wraps to 0 at that edge.
- While in CLEAR:
  - `RF_EN` and `RF_ISSUE_EN` are ignored.
  - `RF_RDATA` = 0, `RF_RBUSY` = 0, `RF_READY` = 0.
- In RUN, `RF_READY` = 1. RUN is left only via `RST`.

Read port i:
- If the address is 0, data = 0 and busy = 0.
- Else, if `RF_EN` and `RF_WA` equals the address, data = `RF_WD` (bypass).
- Otherwise data = `ram[addr]`.
- Busy = `busy[addr]` AND NOT (`RF_EN` and `RF_WA` == addr).

Write: on posedge in RUN with `RF_EN` and `RF_WA` != 0, `ram[RF_WA]` <= `RF_WD` and `busy[RF_WA]` <= 0. Writes to x0 are discarded.

Issue: on posedge in RUN with `RF_ISSUE_EN` and `RF_ISSUE_ADR` != 0, `busy[RF_ISSUE_ADR]` <= 1.

Same address with write and issue in the same cycle: the issue wins, so the busy bit ends at 1 (new producer). The data write still occurs.

Busy bit 0 is constant 0. Duplicate addresses across read ports are legal and return identical values.

## Timing
- Outputs after `RST` assertion: `RF_READY` = 0, `RF_RDATA` = 0, `RF_RBUSY` = 0, all immediately.
- `RF_READY` rises after exactly DEPTH posedges following `RST` deassertion.
- Read latency is 0 cycles (combinational), including the bypass path.
- Write and issue take effect on the next posedge and are visible to an array read in the following cycle.
- `RST` asserted mid-CLEAR or mid-RUN restarts the clear from index 0. Array contents are not guaranteed until `RF_READY`.
- Bypass and busy-mask paths are combinational from `RF_EN`/`RF_WA`/`RF_WD`. Upstream must register these inputs.

## Structure
- Shared package `otter_rf_pkg`: state enum `rf_state_t` {CLEAR, RUN} and default parameter constants `RF_XLEN`, `RF_DEPTH`, `RF_NRD`.
- Sub-module `rf_scoreboard` (params `DEPTH`, `NRD`):
  - holds the busy vector and the issue/write priority;
  - produces `RF_RBUSY`, gated by the ready signal.
- Top level: array, clear FSM, read muxes with bypass.

## Test plan
- Reset, DEPTH=32: pulse `RST`, count edges. Required: `RF_READY` = 0 for 32 edges then 1; every read returns 0.
- Write `RF_WA`=5, `RF_WD`=0xDEADBEEF with port 0 reading 5 in the same cycle. Required: `RF_RDATA[0]` = 0xDEADBEEF combinationally and again next cycle from the array.
- Write to x0 with 0x12345678. Required: reads of x0 return 0 and busy stays 0. Then issue to x0: busy stays 0.
- Issue 7, then 3 cycles later write 7. Required: `RF_RBUSY` for addr 7 is 1 for those cycles, 0 (masked) in the write cycle, and 0 after.
- Simultaneous issue 9 and write 9 (0xA5A5A5A5). Required: read data = 0xA5A5A5A5 and busy = 1 next cycle.
- Assert `RST` at clear index 10, deassert. Required: `RF_READY` rises after a full 32 edges, and reads are 0 throughout.

Source files
------------

// File: rtl/otter_rf_pkg.sv
// Shared definitions for the OTTER bypassing register file.
//   rf_state_t : clear-sequencer state (CLEAR while zeroing the array, RUN after)
//   RF_XLEN    : default data width
//   RF_DEPTH   : default register count (power of two, >= 4)
//   RF_NRD     : default number of combinational read ports
package otter_rf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int RF_XLEN  = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_NRD   = 2;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard used for decode-stage hazard detection.
// A register turns busy when an instruction targeting it issues, and turns
// idle again when writeback writes it. Register 0 is never busy.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears all busy bits)
//   ready           block is in RUN; issue/write ignored and rbusy forced 0 otherwise
//   wr_en, wr_addr  writeback port (clears busy bit)
//   issue_en,
//   issue_addr      issuing instruction's destination (sets busy bit)
//   raddr           packed read addresses, port i = [i*AW +: AW]
//   rbusy           per-port busy flag, masked by a same-cycle write
module rf_scoreboard
  import otter_rf_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int NRD   = RF_NRD,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_addr,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD-1:0]    rbusy
);

  logic [DEPTH-1:0] busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (ready) begin
      if (wr_en && (wr_addr != '0)) begin
        busy[wr_addr] <= 1'b0;
      end
      // NOTE: with non-blocking assignments the last one to the same bit wins,
      // so placing the issue update after the write makes a new producer
      // override the completing one when both hit the same register.
      if (issue_en && (issue_addr != '0)) begin
        busy[issue_addr] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rbusy
    logic [AW-1:0] addr;
    assign addr = raddr[i*AW +: AW];
    // A write landing this cycle resolves the hazard, so mask it early.
    assign rbusy[i] = ready && (addr != '0) && busy[addr]
                      && !(wr_en && (wr_addr == addr));
  end

endmodule

// File: rtl/rf_bypass_sb.sv
// Decode-stage register file for the 5-stage OTTER pipeline.
// NRD combinational read ports with write-through bypass from WB, a busy
// scoreboard for hazard detection, and a post-reset sequencer that zeroes
// one entry per cycle before the block reports ready.
// Ports:
//   CLK, RST        clock, asynchronous active-high reset (restarts the clear)
//   RF_RADDR        packed read addresses, port i = [i*AW +: AW]
//   RF_RDATA        packed read data, port i = [i*XLEN +: XLEN]
//   RF_RBUSY        per-port busy flag for the addressed register
//   RF_WA/WD/EN     writeback port; RF_EN also clears the busy bit of RF_WA
//   RF_ISSUE_EN/ADR instruction writing RF_ISSUE_ADR has issued
//   RF_READY        array cleared, block accepting traffic
module rf_bypass_sb
  import otter_rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int DEPTH = RF_DEPTH,
  parameter int NRD   = RF_NRD,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NRD*AW-1:0]   RF_RADDR,
  output logic [NRD*XLEN-1:0] RF_RDATA,
  output logic [NRD-1:0]      RF_RBUSY,
  input  logic [AW-1:0]       RF_WA,
  input  logic [XLEN-1:0]     RF_WD,
  input  logic                RF_EN,
  input  logic                RF_ISSUE_EN,
  input  logic [AW-1:0]       RF_ISSUE_ADR,
  output logic                RF_READY
);

  rf_state_t         state_q, state_d;
  logic [AW-1:0]     clr_idx;
  logic              ready;
  logic              ram_we;
  logic [AW-1:0]     ram_wa;
  logic [XLEN-1:0]   ram_wd;
  logic [XLEN-1:0]   ram [DEPTH];

  // Clear sequencer: the index runs 0..DEPTH-1 and wraps to 0 on the edge
  // that enters RUN.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= CLEAR;
      clr_idx <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      CLEAR: begin
        if (clr_idx == AW'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        ready = 1'b1;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Single array write port shared by the clear sequencer and writeback;
  // writeback is locked out during CLEAR and x0 writes are dropped.
  always_comb begin
    ram_we = 1'b0;
    ram_wa = clr_idx;
    ram_wd = '0;
    if (!ready) begin
      ram_we = 1'b1;
    end else if (RF_EN && (RF_WA != '0)) begin
      ram_we = 1'b1;
      ram_wa = RF_WA;
      ram_wd = RF_WD;
    end
  end

  // NOTE: the array has no reset; it is zeroed by the clear sequencer so it
  // can map onto plain storage, and reads are gated off until RUN.
  always_ff @(posedge CLK) begin
    if (ram_we) begin
      ram[ram_wa] <= ram_wd;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_read
    logic [AW-1:0] addr;
    logic          hit;
    assign addr = RF_RADDR[i*AW +: AW];
    assign hit  = RF_EN && (RF_WA == addr);
    assign RF_RDATA[i*XLEN +: XLEN] = (!ready || (addr == '0)) ? '0 :
                                      hit                      ? RF_WD :
                                                                 ram[addr];
  end

  rf_scoreboard #(
    .DEPTH (DEPTH),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk        (CLK),
    .rst        (RST),
    .ready      (ready),
    .wr_en      (RF_EN),
    .wr_addr    (RF_WA),
    .issue_en   (RF_ISSUE_EN),
    .issue_addr (RF_ISSUE_ADR),
    .raddr      (RF_RADDR),
    .rbusy      (RF_RBUSY)
  );

  assign RF_READY = ready;

endmodule
